dmi_jtag_ctrl: RTL and testbench
================================

Name: dmi_jtag_ctrl

Overview:
- Parametrised DMI transaction controller in the JTAG TCK domain. Generation 2 of the JTAG DTM front-end.
- Owns the DMI and DTMCS data registers, the request/response sequencing toward the DMI CDC, and sticky error reporting.
- Generalised over the previous version:
  - configurable address width (abits);
  - waits for write responses;
  - propagates response failure as DMIOPFailed;
  - supports dtmcs.dmihardreset, including abort of an in-flight access.
- Sits between dmi_jtag_tap (control strobes) and dmi_cdc (req/resp).

Parameters:
- AddrWidth, 7: DMI address bits (abits). Legal range 7..32.
- IdleCycles, 1: value reported in dtmcs.idle. Legal range 0..7.
- DtmVersion, 1: value reported in dtmcs.version (4 bits).

Ports:
- tck_i  in  1  TCK; all state on the rising edge.
- trst_ni  in  1  Asynchronous reset, active low.
- test_logic_reset_i  in  1  Synchronous clear; same effect as reset.
- capture_dr_i  in  1  TAP Capture-DR strobe.
- shift_dr_i  in  1  TAP Shift-DR strobe.
- update_dr_i  in  1  TAP Update-DR strobe.
- dmi_access_i  in  1  IR selects DMI.
- dtmcs_select_i  in  1  IR selects DTMCS.
- tdi_i  in  1  Serial data in.
- tdo_o  out  1  LSB of the selected register. 0 when neither register is selected.
- dmi_req_addr_o  out  AddrWidth  Request address.
- dmi_req_data_o  out  32  Request write data.
- dmi_req_op_o  out  2  1=read, 2=write.
- dmi_req_valid_o  out  1  Request valid.
- dmi_req_ready_i  in  1  Request accepted.
- dmi_resp_data_i  in  32  Response data.
- dmi_resp_op_i  in  2  0=success, any other value=failed.
- dmi_resp_valid_i  in  1  Response valid.
- dmi_resp_ready_o  out  1  Constant 1.

Behaviour:
- Reset (trst_ni low, or test_logic_reset_i high at a clock edge):
  - dr, dtmcs shift register, address, data, error, abort all 0;
  - state Idle;
  - tdo_o=0, dmi_req_valid_o=0.
- DMI shift register is AddrWidth+34 bits: {addr, data[31:0], op[1:0]}, shifted LSB first.
- Capture-DR, dmi_access_i:
  - loads {address_q, data_q, status};
  - status = error_q when error_q≠0; else 3 (busy) when busy_now; else 0.
  - busy_now = capture in Read/WaitRead/Write/WaitWrite/Drain. It sets error_q=3, which is sticky.
- Capture-DR, dtmcs_select_i: loads {14'b0, 0, 0, 1'b0, IdleCycles[2:0], error_q, AddrWidth[5:0], DtmVersion[3:0]}.
- Shift-DR: right shift of the selected register, tdi_i into the MSB.
- Update-DR, dmi_access_i:
  - In Idle with error_q==0: latch addr/data from the register.
  - op=1 → Read; op=2 → Write; op=0 or 3 → stay Idle, no request.
  - In Idle with error_q≠0: ignored.
  - In any non-Idle state: ignored and error_q=3.
- Update-DR, dtmcs_select_i:
  - bit16 (dmireset) → error_q=0.
  - bit17 (dmihardreset) → error_q=0 and the in-flight access is aborted (see Drain).
  - If both bits are set, hardreset semantics apply.
- States:
  - Idle.
  - Read: valid=1, op=1. On ready → WaitRead.
  - WaitRead: on resp_valid → Idle. If resp_op==0, data_q=resp_data; else error_q=2 (only if error_q==0) and data_q unchanged.
  - Write: valid=1, op=2. On ready → WaitWrite.
  - WaitWrite: on resp_valid → Idle. resp_op≠0 sets error_q=2 (only if error_q==0).
  - Drain: on resp_valid → Idle. Response discarded, no error update.
- Hardreset by state:
  - In Idle: no effect on the state.
  - In Read or Write: set abort_q. valid stays high until ready (a request is never withdrawn), then → Drain.
  - In WaitRead or WaitWrite: → Drain at once.
- Error priority (one level max):
  - dmireset/hardreset clear > busy(3) > failed(2).
  - error_q never downgrades from 3 to 2 without a clear.
  - busy and a clear in the same cycle is impossible (different IR), so no rule is needed.
- Timing:
  - Request valid is asserted the cycle after Update-DR.
  - A response is consumed in the cycle resp_valid is seen; resp_ready is always 1.
  - Minimum read round-trip = 2 cycles + CDC latency.
- Reset mid-transaction: state returns to Idle with no drain. The CDC is reset by the same trst_ni.

Decomposition:
- dm package: dtm_op_e (existing); dmi_error_e {NoError=0, Reserved=1, OpFailed=2, Busy=3}; dtmcs_t packed struct (32 bits).
- Local to the module: state_e {Idle, Read, WaitRead, Write, WaitWrite, Drain}.
- dmi_t is local because its width depends on AddrWidth.
- No sub-module. The two shift registers and the FSM stay in one file.
- dmi_jtag (gen 2) instantiates dmi_jtag_tap + dmi_jtag_ctrl + dmi_cdc.

Test Plan:
- Read, AddrWidth=7: shift {0x10, x, op=1}, update, respond data=0xDEADBEEF op=0 after 3 cycles, then capture → register = {0x10, 0xDEADBEEF, 0}.
- Write: shift {0x04, 0x12345678, 2} → one valid pulse with addr=0x04, data=0x12345678, op=2. Respond op=2 → next DMI capture status=2, dtmcs[11:10]=2.
- Busy: update a read, delay resp 20 cycles, capture mid-wait → status=3. Second update ignored (no new valid). After dtmcs write bit16=1 → status=0.
- Hardreset: update a read, hold ready=0, write dtmcs bit17. valid stays 1 until ready; then the response 0xCAFEF00D is discarded; data_q unchanged; state Idle; error 0.
- AddrWidth=16, IdleCycles=5: dtmcs capture = 0x00005101. A 50-bit DMI shift reaches address 0xABCD on the request.
- Reset mid-WaitWrite: pulse trst_ni low → valid=0, Idle, tdo_o=0. test_logic_reset_i for one cycle gives the identical result.

Source files
------------

// File: rtl/dmi_jtag_ctrl_pkg.sv
// Shared types for the JTAG DTM front-end: DMI op codes, sticky DMI error
// codes and the DTMCS register layout.
package dmi_jtag_ctrl_pkg;

    localparam int unsigned DmiDataWidth = 32;
    localparam int unsigned DmiOpWidth   = 2;

    // Positions of the two self-clearing control bits within DTMCS.
    localparam int unsigned DtmcsDmiResetBit  = 16;
    localparam int unsigned DtmcsHardResetBit = 17;

    typedef enum logic [1:0] {
        DtmNop   = 2'd0,
        DtmRead  = 2'd1,
        DtmWrite = 2'd2
    } dtm_op_e;

    typedef enum logic [1:0] {
        NoError  = 2'd0,
        Reserved = 2'd1,
        OpFailed = 2'd2,
        Busy     = 2'd3
    } dmi_error_e;

    typedef struct packed {
        logic [13:0] zero1;
        logic        dmihardreset;
        logic        dmireset;
        logic        zero0;
        logic [2:0]  idle;
        logic [1:0]  dmistat;
        logic [5:0]  abits;
        logic [3:0]  version;
    } dtmcs_t;

endpackage

// File: rtl/dmi_jtag_ctrl.sv
// DMI transaction controller in the TCK domain: owns the DMI and DTMCS data
// registers, sequences requests/responses toward the DMI CDC and keeps the
// sticky DMI error status.
//
// state     | meaning
// ----------+------------------------------------------------------------
// Idle      | no access outstanding; Update-DR on DMI may start one
// Read      | read request presented, waiting for the CDC to accept it
// WaitRead  | read accepted, waiting for its response
// Write     | write request presented, waiting for the CDC to accept it
// WaitWrite | write accepted, waiting for its response
// Drain     | access aborted by dmihardreset; swallow its response
module dmi_jtag_ctrl
    import dmi_jtag_ctrl_pkg::*;
#(
    parameter int unsigned AddrWidth  = 7,
    parameter int unsigned IdleCycles = 1,
    parameter int unsigned DtmVersion = 1
) (
    input  logic                    tck_i,
    input  logic                    trst_ni,
    input  logic                    test_logic_reset_i,
    input  logic                    capture_dr_i,
    input  logic                    shift_dr_i,
    input  logic                    update_dr_i,
    input  logic                    dmi_access_i,
    input  logic                    dtmcs_select_i,
    input  logic                    tdi_i,
    output logic                    tdo_o,
    output logic [AddrWidth-1:0]    dmi_req_addr_o,
    output logic [DmiDataWidth-1:0] dmi_req_data_o,
    output logic [DmiOpWidth-1:0]   dmi_req_op_o,
    output logic                    dmi_req_valid_o,
    input  logic                    dmi_req_ready_i,
    input  logic [DmiDataWidth-1:0] dmi_resp_data_i,
    input  logic [DmiOpWidth-1:0]   dmi_resp_op_i,
    input  logic                    dmi_resp_valid_i,
    output logic                    dmi_resp_ready_o
);

    localparam int unsigned DmiWidth = AddrWidth + DmiDataWidth + DmiOpWidth;

    typedef struct packed {
        logic [AddrWidth-1:0]    address;
        logic [DmiDataWidth-1:0] data;
        logic [DmiOpWidth-1:0]   op;
    } dmi_t;

    typedef enum logic [2:0] {
        Idle,
        Read,
        WaitRead,
        Write,
        WaitWrite,
        Drain
    } state_e;

    logic [DmiWidth-1:0]     dmi_sr_q;
    logic [31:0]             dtmcs_sr_q;
    dmi_t                    dmi_sr;

    state_e                  state_q;
    logic [AddrWidth-1:0]    address_q;
    logic [DmiDataWidth-1:0] data_q;
    dmi_error_e              error_q;
    logic                    abort_q;
    logic                    req_valid_q;
    dtm_op_e                 req_op_q;

    logic                    busy_now;
    logic                    dmi_capture;
    logic                    dmi_update;
    logic                    dtmcs_update;
    logic                    dmi_reset;
    logic                    hard_reset;
    logic                    clear_error;
    dmi_error_e              capture_status;
    dtmcs_t                  dtmcs_capture;

    assign dmi_sr = dmi_sr_q;

    assign busy_now     = (state_q != Idle);
    assign dmi_capture  = capture_dr_i && dmi_access_i;
    assign dmi_update   = update_dr_i && dmi_access_i;
    assign dtmcs_update = update_dr_i && dtmcs_select_i;
    assign dmi_reset    = dtmcs_update && dtmcs_sr_q[DtmcsDmiResetBit];
    assign hard_reset   = dtmcs_update && dtmcs_sr_q[DtmcsHardResetBit];
    assign clear_error  = dmi_reset || hard_reset;

    // Status field returned on a DMI capture: a sticky error wins over busy.
    always_comb begin
        capture_status = NoError;
        if (error_q != NoError) begin
            capture_status = error_q;
        end else if (busy_now) begin
            capture_status = Busy;
        end
    end

    // Read-only DTMCS image; the reset request bits always read back as zero.
    always_comb begin
        dtmcs_capture         = '0;
        dtmcs_capture.idle    = 3'(IdleCycles);
        dtmcs_capture.dmistat = error_q;
        dtmcs_capture.abits   = 6'(AddrWidth);
        dtmcs_capture.version = 4'(DtmVersion);
    end

    // Capture/shift of the DMI and DTMCS data registers, LSB shifted out first.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            dmi_sr_q   <= '0;
            dtmcs_sr_q <= '0;
        end else if (test_logic_reset_i) begin
            dmi_sr_q   <= '0;
            dtmcs_sr_q <= '0;
        end else begin
            if (dmi_access_i) begin
                if (capture_dr_i) begin
                    dmi_sr_q <= {address_q, data_q, capture_status};
                end else if (shift_dr_i) begin
                    dmi_sr_q <= {tdi_i, dmi_sr_q[DmiWidth-1:1]};
                end
            end
            if (dtmcs_select_i) begin
                if (capture_dr_i) begin
                    dtmcs_sr_q <= dtmcs_capture;
                end else if (shift_dr_i) begin
                    dtmcs_sr_q <= {tdi_i, dtmcs_sr_q[31:1]};
                end
            end
        end
    end

    // Request/response sequencing plus sticky error tracking.
    // Error writes are ordered so later ones win: failed < busy < clear.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q     <= Idle;
            address_q   <= '0;
            data_q      <= '0;
            error_q     <= NoError;
            abort_q     <= 1'b0;
            req_valid_q <= 1'b0;
            req_op_q    <= DtmNop;
        end else if (test_logic_reset_i) begin
            state_q     <= Idle;
            address_q   <= '0;
            data_q      <= '0;
            error_q     <= NoError;
            abort_q     <= 1'b0;
            req_valid_q <= 1'b0;
            req_op_q    <= DtmNop;
        end else begin
            unique case (state_q)
                Idle: begin
                    if (dmi_update && (error_q == NoError)) begin
                        address_q <= dmi_sr.address;
                        data_q    <= dmi_sr.data;
                        if (dmi_sr.op == DtmRead) begin
                            state_q     <= Read;
                            req_valid_q <= 1'b1;
                            req_op_q    <= DtmRead;
                        end else if (dmi_sr.op == DtmWrite) begin
                            state_q     <= Write;
                            req_valid_q <= 1'b1;
                            req_op_q    <= DtmWrite;
                        end
                    end
                end
                Read, Write: begin
                    // A presented request is never withdrawn; an abort only
                    // redirects where the accepted access ends up.
                    if (dmi_req_ready_i) begin
                        req_valid_q <= 1'b0;
                        abort_q     <= 1'b0;
                        if (abort_q || hard_reset) begin
                            state_q <= Drain;
                        end else if (state_q == Read) begin
                            state_q <= WaitRead;
                        end else begin
                            state_q <= WaitWrite;
                        end
                    end else if (hard_reset) begin
                        abort_q <= 1'b1;
                    end
                end
                WaitRead, WaitWrite: begin
                    if (dmi_resp_valid_i) begin
                        state_q <= Idle;
                        // A hardreset landing with the response discards it.
                        if (!hard_reset) begin
                            if (dmi_resp_op_i == 2'd0) begin
                                if (state_q == WaitRead) begin
                                    data_q <= dmi_resp_data_i;
                                end
                            end else if (error_q == NoError) begin
                                error_q <= OpFailed;
                            end
                        end
                    end else if (hard_reset) begin
                        state_q <= Drain;
                    end
                end
                Drain: begin
                    if (dmi_resp_valid_i) begin
                        state_q <= Idle;
                    end
                end
                default: begin
                    state_q     <= Idle;
                    req_valid_q <= 1'b0;
                    abort_q     <= 1'b0;
                end
            endcase

            if ((dmi_capture || dmi_update) && busy_now) begin
                error_q <= Busy;
            end
            if (clear_error) begin
                error_q <= NoError;
            end
        end
    end

    assign tdo_o = dmi_access_i   ? dmi_sr_q[0]   :
                   dtmcs_select_i ? dtmcs_sr_q[0] : 1'b0;

    assign dmi_req_addr_o   = address_q;
    assign dmi_req_data_o   = data_q;
    assign dmi_req_op_o     = req_op_q;
    assign dmi_req_valid_o  = req_valid_q;
    assign dmi_resp_ready_o = 1'b1;

endmodule

// File: tb/tb_dmi_jtag_ctrl.sv
// Bench for dmi_jtag_ctrl: one 7-bit-address instance driven by directed and
// random DMI/DTMCS scans against a small register/transaction model, and one
// 16-bit-address instance for the width-dependent behaviour.
module tb_dmi_jtag_ctrl;

    localparam int AW1 = 7;
    localparam int AW2 = 16;
    localparam int W1  = AW1 + 34;
    localparam int W2  = AW2 + 34;

    logic tck = 1'b0;
    always #5 tck = ~tck;

    logic trst_n, tlr, capture, shift, update, tdi;
    logic acc1, sel1, acc2, sel2;
    logic tdo1, tdo2;

    logic [AW1-1:0] addr1;
    logic [31:0]    wdata1, rdata1;
    logic [1:0]     op1, rop1;
    logic           valid1, ready1, rvalid1, rready1;

    logic [AW2-1:0] addr2;
    logic [31:0]    wdata2, rdata2;
    logic [1:0]     op2, rop2;
    logic           valid2, ready2, rvalid2, rready2;

    dmi_jtag_ctrl #(.AddrWidth(AW1), .IdleCycles(1), .DtmVersion(1)) dut1 (
        .tck_i(tck), .trst_ni(trst_n), .test_logic_reset_i(tlr),
        .capture_dr_i(capture), .shift_dr_i(shift), .update_dr_i(update),
        .dmi_access_i(acc1), .dtmcs_select_i(sel1), .tdi_i(tdi), .tdo_o(tdo1),
        .dmi_req_addr_o(addr1), .dmi_req_data_o(wdata1), .dmi_req_op_o(op1),
        .dmi_req_valid_o(valid1), .dmi_req_ready_i(ready1),
        .dmi_resp_data_i(rdata1), .dmi_resp_op_i(rop1),
        .dmi_resp_valid_i(rvalid1), .dmi_resp_ready_o(rready1)
    );

    dmi_jtag_ctrl #(.AddrWidth(AW2), .IdleCycles(5), .DtmVersion(1)) dut2 (
        .tck_i(tck), .trst_ni(trst_n), .test_logic_reset_i(tlr),
        .capture_dr_i(capture), .shift_dr_i(shift), .update_dr_i(update),
        .dmi_access_i(acc2), .dtmcs_select_i(sel2), .tdi_i(tdi), .tdo_o(tdo2),
        .dmi_req_addr_o(addr2), .dmi_req_data_o(wdata2), .dmi_req_op_o(op2),
        .dmi_req_valid_o(valid2), .dmi_req_ready_i(ready2),
        .dmi_resp_data_i(rdata2), .dmi_resp_op_i(rop2),
        .dmi_resp_valid_i(rvalid2), .dmi_resp_ready_o(rready2)
    );

    int errors = 0;
    int checks = 0;

    // Model of the 7-bit instance: latched address/data and sticky error.
    logic [AW1-1:0] m_addr;
    logic [31:0]    m_data;
    logic [1:0]     m_err;

    logic [63:0]    dout;
    logic [AW1-1:0] ra;
    logic [31:0]    rd;
    logic [1:0]     rop, rop_resp, err_before;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_sel(input bit which, input bit dmi, input bit on);
        if (which) begin
            acc2 = dmi & on;
            sel2 = !dmi & on;
        end else begin
            acc1 = dmi & on;
            sel1 = !dmi & on;
        end
    endtask

    // Capture, shift w bits (returning what came out of tdo), then update.
    task automatic scan(input bit which, input bit dmi, input int w,
                        input logic [63:0] din, output logic [63:0] so);
        so = '0;
        @(negedge tck);
        set_sel(which, dmi, 1'b1);
        capture = 1'b1;
        @(negedge tck);
        capture = 1'b0;
        shift   = 1'b1;
        for (int i = 0; i < w; i++) begin
            so[i] = which ? tdo2 : tdo1;
            tdi   = din[i];
            @(negedge tck);
        end
        shift  = 1'b0;
        update = 1'b1;
        @(negedge tck);
        update = 1'b0;
        set_sel(which, dmi, 1'b0);
    endtask

    // DMI scan on instance 1; busy says an access is outstanding at capture.
    task automatic dmi_scan1(input string tag, input logic [AW1-1:0] a,
                             input logic [31:0] d, input logic [1:0] op, input bit busy);
        logic [1:0]  st;
        logic [63:0] so;
        st = (m_err != 2'd0) ? m_err : (busy ? 2'd3 : 2'd0);
        scan(1'b0, 1'b1, W1, {23'b0, a, d, op}, so);
        chk({tag, " dmi capture"}, so, {23'b0, m_addr, m_data, st});
        if (busy) begin
            m_err = 2'd3;
        end else if (m_err == 2'd0) begin
            m_addr = a;
            m_data = d;
        end
    endtask

    task automatic dtmcs_scan1(input string tag, input logic [31:0] din);
        logic [63:0] so;
        logic [31:0] exp;
        exp = (32'd1 << 12) | (32'(m_err) << 10) | (32'd7 << 4) | 32'd1;
        scan(1'b0, 1'b0, 32, {32'b0, din}, so);
        chk({tag, " dtmcs capture"}, so, {32'b0, exp});
        if (din[16] || din[17]) m_err = 2'd0;
    endtask

    task automatic req_check1(input string tag, input bit is_read);
        chk({tag, " req valid"}, valid1, 1);
        chk({tag, " req addr"}, addr1, m_addr);
        chk({tag, " req op"}, op1, is_read ? 2'd1 : 2'd2);
        if (!is_read) chk({tag, " req data"}, wdata1, m_data);
    endtask

    task automatic accept1(input string tag, input int dly);
        repeat (dly) @(negedge tck);
        chk({tag, " valid held"}, valid1, 1);
        ready1 = 1'b1;
        @(negedge tck);
        ready1 = 1'b0;
        chk({tag, " valid dropped"}, valid1, 0);
    endtask

    task automatic resp_raw1(input int dly, input logic [31:0] d, input logic [1:0] op);
        repeat (dly) @(negedge tck);
        rvalid1 = 1'b1;
        rdata1  = d;
        rop1    = op;
        @(negedge tck);
        rvalid1 = 1'b0;
        rdata1  = '0;
        rop1    = '0;
    endtask

    task automatic respond1(input int dly, input bit is_read, input logic [31:0] d, input logic [1:0] op);
        resp_raw1(dly, d, op);
        if (op == 2'd0) begin
            if (is_read) m_data = d;
        end else if (m_err == 2'd0) begin
            m_err = 2'd2;
        end
    endtask

    // Mid-WaitWrite reset, via trst_n or via one cycle of test_logic_reset.
    task automatic rst_case(input string tag, input bit use_tlr);
        dmi_scan1({tag, " wr"}, 7'h05, 32'hA5A5A5A5, 2'd2, 1'b0);
        req_check1({tag, " wr"}, 1'b0);
        accept1({tag, " wr"}, 1);
        dmi_scan1({tag, " busy"}, 7'h00, 32'h0, 2'd0, 1'b1);
        dtmcs_scan1({tag, " pre"}, 32'h1);
        sel1 = 1'b1;
        @(negedge tck);
        chk({tag, " tdo before"}, tdo1, 1);
        if (use_tlr) begin
            tlr = 1'b1;
            @(negedge tck);
            tlr = 1'b0;
        end else begin
            trst_n = 1'b0;
            #1;
        end
        chk({tag, " valid"}, valid1, 0);
        chk({tag, " tdo"}, tdo1, 0);
        if (!use_tlr) begin
            @(negedge tck);
            trst_n = 1'b1;
        end
        sel1   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_err  = '0;
        dtmcs_scan1({tag, " after"}, 32'h0);
        dmi_scan1({tag, " after"}, 7'h00, 32'h0, 2'd0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the bench finished");
        $fatal(1, "watchdog");
    end

    initial begin
        trst_n = 1'b0; tlr = 1'b0; capture = 1'b0; shift = 1'b0; update = 1'b0; tdi = 1'b0;
        acc1 = 1'b1; sel1 = 1'b0; acc2 = 1'b0; sel2 = 1'b0;
        ready1 = 1'b0; rvalid1 = 1'b0; rdata1 = '0; rop1 = '0;
        ready2 = 1'b0; rvalid2 = 1'b0; rdata2 = '0; rop2 = '0;
        m_addr = '0; m_data = '0; m_err = '0;
        repeat (3) @(negedge tck);
        chk("reset valid", valid1, 0);
        chk("reset tdo", tdo1, 0);
        chk("resp ready", rready1, 1);
        chk("reset valid2", valid2, 0);
        acc1   = 1'b0;
        trst_n = 1'b1;
        @(negedge tck);
        dmi_scan1("reset", 7'h00, 32'h0, 2'd0, 1'b0);

        // Read round trip.
        dmi_scan1("read", 7'h10, 32'h0, 2'd1, 1'b0);
        req_check1("read", 1'b1);
        accept1("read", 0);
        respond1(3, 1'b1, 32'hDEADBEEF, 2'd0);
        dmi_scan1("read result", 7'h10, 32'h0, 2'd0, 1'b0);

        // Failed write leaves a sticky OpFailed.
        dmi_scan1("write", 7'h04, 32'h12345678, 2'd2, 1'b0);
        req_check1("write", 1'b0);
        accept1("write", 1);
        respond1(2, 1'b0, 32'h0, 2'd2);
        dtmcs_scan1("write err", 32'h0);
        dmi_scan1("write status", 7'h04, 32'h12345678, 2'd0, 1'b0);
        dtmcs_scan1("dmireset", 32'h1 << 16);

        // Capture while a read is outstanding reports and latches busy.
        dmi_scan1("busy rd", 7'h22, 32'h55, 2'd1, 1'b0);
        req_check1("busy rd", 1'b1);
        accept1("busy rd", 0);
        dmi_scan1("busy mid", 7'h33, 32'h66, 2'd1, 1'b1);
        chk("busy no new req", valid1, 0);
        respond1(2, 1'b1, 32'h0BADCAFE, 2'd0);
        chk("busy no new req after", valid1, 0);
        dtmcs_scan1("busy clear", 32'h1 << 16);
        dmi_scan1("busy cleared", 7'h22, 32'h0, 2'd0, 1'b0);

        // Hardreset while the request is still unaccepted.
        dmi_scan1("hr rd", 7'h11, 32'h13579BDF, 2'd1, 1'b0);
        req_check1("hr rd", 1'b1);
        dtmcs_scan1("hr", 32'h1 << 17);
        accept1("hr rd", 3);
        resp_raw1(2, 32'hCAFEF00D, 2'd0);
        dmi_scan1("hr after", 7'h11, 32'h13579BDF, 2'd1, 1'b0);
        req_check1("hr next", 1'b1);
        accept1("hr next", 0);
        respond1(1, 1'b1, 32'h76543210, 2'd0);

        // Hardreset while waiting for the response.
        dmi_scan1("hr wait", 7'h12, 32'h2468ACE0, 2'd1, 1'b0);
        req_check1("hr wait", 1'b1);
        accept1("hr wait", 0);
        dtmcs_scan1("hr wait", 32'h1 << 17);
        resp_raw1(1, 32'hFEEDFACE, 2'd3);
        dmi_scan1("hr wait after", 7'h12, 32'h0, 2'd0, 1'b0);

        rst_case("trst", 1'b0);
        rst_case("tlr", 1'b1);

        // Random traffic against the model.
        for (int it = 0; it < 40; it++) begin
            ra  = 7'($urandom);
            rd  = $urandom;
            rop = 2'($urandom_range(0, 3));
            err_before = m_err;
            dmi_scan1("rand", ra, rd, rop, 1'b0);
            if (err_before == 2'd0 && (rop == 2'd1 || rop == 2'd2)) begin
                req_check1("rand", rop == 2'd1);
                accept1("rand", $urandom_range(0, 3));
                rop_resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
                respond1($urandom_range(0, 4), rop == 2'd1, $urandom, rop_resp);
            end else begin
                chk("rand no req", valid1, 0);
            end
            if ($urandom_range(0, 2) == 0) dtmcs_scan1("rand", $urandom);
        end

        // Wider address instance.
        scan(1'b1, 1'b0, 32, 64'h0, dout);
        chk("aw16 dtmcs", dout, 64'h5101);
        rd = $urandom;
        scan(1'b1, 1'b1, W2, {14'b0, 16'hABCD, rd, 2'd2}, dout);
        chk("aw16 first capture", dout, 64'h0);
        chk("aw16 valid", valid2, 1);
        chk("aw16 addr", addr2, 16'hABCD);
        chk("aw16 data", wdata2, rd);
        chk("aw16 op", op2, 2'd2);
        ready2 = 1'b1;
        @(negedge tck);
        ready2 = 1'b0;
        chk("aw16 valid dropped", valid2, 0);
        rvalid2 = 1'b1;
        @(negedge tck);
        rvalid2 = 1'b0;
        scan(1'b1, 1'b1, W2, 64'h0, dout);
        chk("aw16 capture", dout, {14'b0, 16'hABCD, rd, 2'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
